// File: rtl/regfile_mp_sb_pkg.sv
// regfile_mp_sb_pkg: shared widths, address helper and writeback request type
package regfile_mp_sb_pkg;
    localparam int XLEN_DEF = 32;
    localparam int NREGS_DEF = 32;
    function automatic int addr_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
    typedef logic [addr_w(NREGS_DEF)-1:0] reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xword_t;
    typedef struct packed {
        logic      en;
        reg_addr_t addr;
        xword_t    data;
    } wr_req_t;
endpackage

// File: rtl/regfile_mp_sb_if.sv
// regfile_mp_sb_if: decode/writeback/issue bundle between the pipeline and the register file
interface regfile_mp_sb_if
    import regfile_mp_sb_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
);
    localparam int AW = addr_w(NREGS);
    logic [NUM_RD-1:0][AW-1:0]   rd_addr;
    logic [NUM_RD-1:0][XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]           rd_busy;
    logic [NUM_WR-1:0]           wr_en;
    logic [NUM_WR-1:0][AW-1:0]   wr_addr;
    logic [NUM_WR-1:0][XLEN-1:0] wr_data;
    logic                        alloc_en;
    logic [AW-1:0]               alloc_rd;
    logic                        flush;
    logic [AW:0]                 pending_cnt;
    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_rd, flush,
        input  rd_data, rd_busy, pending_cnt
    );
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_rd, flush,
        output rd_data, rd_busy, pending_cnt
    );
endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// regfile_mp_sb_scoreboard: pending-write vector with flush > alloc > writeback priority and popcount
module regfile_mp_sb_scoreboard #(
    parameter int NREGS    = 32,
    parameter int NUM_WR   = 1,
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_WR-1:0]         wr_en,
    input  logic [NUM_WR-1:0][AW-1:0] wr_addr,
    input  logic                      alloc_en,
    input  logic [AW-1:0]             alloc_rd,
    input  logic                      flush,
    output logic [NREGS-1:0]          pending,
    output logic [AW:0]               pending_cnt
);
    logic [NREGS-1:0] nxt;
    logic [AW:0]      cnt;
    always_comb begin
        nxt = pending;
        for (int j = 0; j < NUM_WR; j++)
            if (wr_en[j]) nxt[wr_addr[j]] = 1'b0;
        if (alloc_en) nxt[alloc_rd] = 1'b1;
        if (ZERO_REG) nxt[0] = 1'b0;
        if (flush) nxt = '0;
        cnt = '0;
        for (int r = 0; r < NREGS; r++)
            cnt = cnt + {{AW{1'b0}}, nxt[r]};
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pending     <= '0;
            pending_cnt <= '0;
        end else begin
            pending     <= nxt;
            pending_cnt <= cnt;
        end
endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with same-cycle write bypass and pending-write scoreboard
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter bit ZERO_REG = 1'b1
) (
    input logic clk,
    input logic rst_n,
    regfile_mp_sb_if.slave bus
);
    localparam int AW = addr_w(NREGS);
    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pending;
    // later ports overwrite earlier ones in loop order, so the youngest writer wins
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++)
                if (bus.wr_en[j] && !(ZERO_REG && bus.wr_addr[j] == '0))
                    regs[bus.wr_addr[j]] <= bus.wr_data[j];
        end
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic            hit;
        logic            zero;
        logic [XLEN-1:0] byp;
        always_comb begin
            hit = 1'b0;
            byp = '0;
            for (int j = 0; j < NUM_WR; j++)
                if (bus.wr_en[j] && bus.wr_addr[j] == bus.rd_addr[i]) begin
                    hit = 1'b1;
                    byp = bus.wr_data[j];
                end
        end
        assign zero = ZERO_REG && bus.rd_addr[i] == '0;
        assign bus.rd_data[i] = zero ? '0 : hit ? byp : regs[bus.rd_addr[i]];
        assign bus.rd_busy[i] = pending[bus.rd_addr[i]] && !hit && !zero;
    end
    regfile_mp_sb_scoreboard #(
        .NREGS(NREGS), .NUM_WR(NUM_WR), .AW(AW), .ZERO_REG(ZERO_REG)
    ) u_sb (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(bus.wr_en),
        .wr_addr(bus.wr_addr),
        .alloc_en(bus.alloc_en),
        .alloc_rd(bus.alloc_rd),
        .flush(bus.flush),
        .pending(pending),
        .pending_cnt(bus.pending_cnt)
    );
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: scenario tasks with a queue of expected values, 2R2W configuration
module tb_regfile_mp_sb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;
    logic [31:0] model [32];
    always #5 clk = ~clk;
    regfile_mp_sb_if #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2)) bus();
    regfile_mp_sb #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1'b1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    task automatic idle;
        bus.wr_en = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.alloc_en = 1'b0;
        bus.alloc_rd = '0;
        bus.flush = 1'b0;
    endtask
    task automatic cyc;
        @(posedge clk);
        #1;
        idle();
    endtask
    task automatic test_reset;
        idle();
        bus.rd_addr = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.rd_addr[0] = 5'd1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); tests++;
        if (bus.rd_data[0] !== e) begin fails++; $display("FAIL rst_data got=%h exp=%h", bus.rd_data[0], e); end
        e = exp_q.pop_front(); tests++;
        if (32'(bus.pending_cnt) !== e) begin fails++; $display("FAIL rst_cnt got=%0d exp=%0d", bus.pending_cnt, e); end
        rst_n = 1'b1;
        cyc();
        bus.wr_en[0] = 1'b1; bus.wr_addr[0] = 5'd5; bus.wr_data[0] = 32'hDEADBEEF;
        bus.alloc_en = 1'b1; bus.alloc_rd = 5'd8;
        cyc();
        bus.rd_addr[0] = 5'd5; bus.rd_addr[1] = 5'd8;
        exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'd1); exp_q.push_back(32'd1);
        @(negedge clk);
        e = exp_q.pop_front(); tests++;
        if (bus.rd_data[0] !== e) begin fails++; $display("FAIL pre_rst_x5 got=%h exp=%h", bus.rd_data[0], e); end
        e = exp_q.pop_front(); tests++;
        if (32'(bus.rd_busy[1]) !== e) begin fails++; $display("FAIL pre_rst_busy got=%0d exp=%0d", bus.rd_busy[1], e); end
        e = exp_q.pop_front(); tests++;
        if (32'(bus.pending_cnt) !== e) begin fails++; $display("FAIL pre_rst_cnt got=%0d exp=%0d", bus.pending_cnt, e); end
        #1 rst_n = 1'b0;
        exp_q.push_back(32'h0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); tests++;
        if (bus.rd_data[0] !== e) begin fails++; $display("FAIL async_rst_x5 got=%h exp=%h", bus.rd_data[0], e); end
        e = exp_q.pop_front(); tests++;
        if (32'(bus.rd_busy[1]) !== e) begin fails++; $display("FAIL async_rst_busy got=%0d exp=%0d", bus.rd_busy[1], e); end
        e = exp_q.pop_front(); tests++;
        if (32'(bus.pending_cnt) !== e) begin fails++; $display("FAIL async_rst_cnt got=%0d exp=%0d", bus.pending_cnt, e); end
        #1 rst_n = 1'b1;
    endtask
    task automatic test_bypass;
        cyc();
        bus.alloc_en = 1'b1; bus.alloc_rd = 5'd7; bus.rd_addr[0] = 5'd7;
        exp_q.push_back(32'd0);
        @(negedge clk);
        e = exp_q.pop_front(); tests++;
        if (32'(bus.rd_busy[0]) !== e) begin fails++; $display("FAIL alloc_same_cycle_busy got=%0d exp=%0d", bus.rd_busy[0], e); end
        cyc();
        bus.wr_en[0] = 1'b1; bus.wr_addr[0] = 5'd7; bus.wr_data[0] = 32'h1234;
        exp_q.push_back(32'h1234); exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        @(negedge clk);
        e = exp_q.pop_front(); tests++;
        if (bus.rd_data[0] !== e) begin fails++; $display("FAIL bypass_data got=%h exp=%h", bus.rd_data[0], e); end
        e = exp_q.pop_front(); tests++;
        if (32'(bus.rd_busy[0]) !== e) begin fails++; $display("FAIL bypass_busy got=%0d exp=%0d", bus.rd_busy[0], e); end
        e = exp_q.pop_front(); tests++;
        if (32'(bus.pending_cnt) !== e) begin fails++; $display("FAIL bypass_cnt got=%0d exp=%0d", bus.pending_cnt, e); end
        cyc();
        exp_q.push_back(32'h1234); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        @(negedge clk);
        e = exp_q.pop_front(); tests++;
        if (bus.rd_data[0] !== e) begin fails++; $display("FAIL stored_data got=%h exp=%h", bus.rd_data[0], e); end
        e = exp_q.pop_front(); tests++;
        if (32'(bus.rd_busy[0]) !== e) begin fails++; $display("FAIL stored_busy got=%0d exp=%0d", bus.rd_busy[0], e); end
        e = exp_q.pop_front(); tests++;
        if (32'(bus.pending_cnt) !== e) begin fails++; $display("FAIL stored_cnt got=%0d exp=%0d", bus.pending_cnt, e); end
    endtask
    task automatic test_dual_write;
        cyc();
        bus.wr_en = 2'b11; bus.wr_addr[0] = 5'd3; bus.wr_addr[1] = 5'd3;
        bus.wr_data[0] = 32'hA; bus.wr_data[1] = 32'hB;
        bus.rd_addr[0] = 5'd3; bus.rd_addr[1] = 5'd3;
        exp_q.push_back(32'hB);
        @(negedge clk);
        e = exp_q.pop_front(); tests++;
        if (bus.rd_data[1] !== e) begin fails++; $display("FAIL dual_bypass got=%h exp=%h", bus.rd_data[1], e); end
        cyc();
        exp_q.push_back(32'hB);
        @(negedge clk);
        e = exp_q.pop_front(); tests++;
        if (bus.rd_data[0] !== e) begin fails++; $display("FAIL dual_stored got=%h exp=%h", bus.rd_data[0], e); end
        cyc();
        bus.wr_en = 2'b11; bus.wr_addr[0] = 5'd10; bus.wr_addr[1] = 5'd11;
        bus.wr_data[0] = 32'h10; bus.wr_data[1] = 32'h11;
        bus.rd_addr[0] = 5'd11; bus.rd_addr[1] = 5'd10;
        exp_q.push_back(32'h11); exp_q.push_back(32'h10);
        @(negedge clk);
        e = exp_q.pop_front(); tests++;
        if (bus.rd_data[0] !== e) begin fails++; $display("FAIL split_bypass0 got=%h exp=%h", bus.rd_data[0], e); end
        e = exp_q.pop_front(); tests++;
        if (bus.rd_data[1] !== e) begin fails++; $display("FAIL split_bypass1 got=%h exp=%h", bus.rd_data[1], e); end
        cyc();
        exp_q.push_back(32'h11); exp_q.push_back(32'h10);
        @(negedge clk);
        e = exp_q.pop_front(); tests++;
        if (bus.rd_data[0] !== e) begin fails++; $display("FAIL split_stored0 got=%h exp=%h", bus.rd_data[0], e); end
        e = exp_q.pop_front(); tests++;
        if (bus.rd_data[1] !== e) begin fails++; $display("FAIL split_stored1 got=%h exp=%h", bus.rd_data[1], e); end
    endtask
    task automatic test_hazard;
        cyc();
        bus.alloc_en = 1'b1; bus.alloc_rd = 5'd9; bus.rd_addr[0] = 5'd9;
        cyc();
        exp_q.push_back(32'd1); exp_q.push_back(32'd1);
        @(negedge clk);
        e = exp_q.pop_front(); tests++;
        if (32'(bus.rd_busy[0]) !== e) begin fails++; $display("FAIL hazard_busy got=%0d exp=%0d", bus.rd_busy[0], e); end
        e = exp_q.pop_front(); tests++;
        if (32'(bus.pending_cnt) !== e) begin fails++; $display("FAIL hazard_cnt got=%0d exp=%0d", bus.pending_cnt, e); end
        cyc();
        bus.wr_en[0] = 1'b1; bus.wr_addr[0] = 5'd9; bus.wr_data[0] = 32'h55;
        exp_q.push_back(32'd0); exp_q.push_back(32'h55);
        @(negedge clk);
        e = exp_q.pop_front(); tests++;
        if (32'(bus.rd_busy[0]) !== e) begin fails++; $display("FAIL wb_busy got=%0d exp=%0d", bus.rd_busy[0], e); end
        e = exp_q.pop_front(); tests++;
        if (bus.rd_data[0] !== e) begin fails++; $display("FAIL wb_data got=%h exp=%h", bus.rd_data[0], e); end
        cyc();
        exp_q.push_back(32'd0);
        @(negedge clk);
        e = exp_q.pop_front(); tests++;
        if (32'(bus.pending_cnt) !== e) begin fails++; $display("FAIL wb_cnt got=%0d exp=%0d", bus.pending_cnt, e); end
    endtask
    task automatic test_collision_flush;
        cyc();
        bus.alloc_en = 1'b1; bus.alloc_rd = 5'd4;
        bus.wr_en[0] = 1'b1; bus.wr_addr[0] = 5'd4; bus.wr_data[0] = 32'h44;
        cyc();
        bus.alloc_en = 1'b1; bus.alloc_rd = 5'd12; bus.rd_addr[0] = 5'd4;
        exp_q.push_back(32'd1); exp_q.push_back(32'h44); exp_q.push_back(32'd1);
        @(negedge clk);
        e = exp_q.pop_front(); tests++;
        if (32'(bus.rd_busy[0]) !== e) begin fails++; $display("FAIL coll_busy got=%0d exp=%0d", bus.rd_busy[0], e); end
        e = exp_q.pop_front(); tests++;
        if (bus.rd_data[0] !== e) begin fails++; $display("FAIL coll_data got=%h exp=%h", bus.rd_data[0], e); end
        e = exp_q.pop_front(); tests++;
        if (32'(bus.pending_cnt) !== e) begin fails++; $display("FAIL coll_cnt got=%0d exp=%0d", bus.pending_cnt, e); end
        cyc();
        bus.flush = 1'b1; bus.alloc_en = 1'b1; bus.alloc_rd = 5'd6;
        bus.wr_en[1] = 1'b1; bus.wr_addr[1] = 5'd13; bus.wr_data[1] = 32'h77;
        bus.rd_addr[1] = 5'd12;
        exp_q.push_back(32'd1); exp_q.push_back(32'd2);
        @(negedge clk);
        e = exp_q.pop_front(); tests++;
        if (32'(bus.rd_busy[1]) !== e) begin fails++; $display("FAIL preflush_busy got=%0d exp=%0d", bus.rd_busy[1], e); end
        e = exp_q.pop_front(); tests++;
        if (32'(bus.pending_cnt) !== e) begin fails++; $display("FAIL preflush_cnt got=%0d exp=%0d", bus.pending_cnt, e); end
        cyc();
        bus.rd_addr[0] = 5'd6; bus.rd_addr[1] = 5'd13;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'h77);
        @(negedge clk);
        e = exp_q.pop_front(); tests++;
        if (32'(bus.pending_cnt) !== e) begin fails++; $display("FAIL flush_cnt got=%0d exp=%0d", bus.pending_cnt, e); end
        e = exp_q.pop_front(); tests++;
        if (32'(bus.rd_busy[0]) !== e) begin fails++; $display("FAIL flush_alloc_busy got=%0d exp=%0d", bus.rd_busy[0], e); end
        e = exp_q.pop_front(); tests++;
        if (bus.rd_data[1] !== e) begin fails++; $display("FAIL flush_write got=%h exp=%h", bus.rd_data[1], e); end
    endtask
    task automatic test_x0;
        cyc();
        bus.alloc_en = 1'b1; bus.alloc_rd = 5'd20;
        cyc();
        bus.wr_en[0] = 1'b1; bus.wr_addr[0] = 5'd0; bus.wr_data[0] = 32'hFF;
        bus.alloc_en = 1'b1; bus.alloc_rd = 5'd0; bus.rd_addr[0] = 5'd0;
        exp_q.push_back(32'h0); exp_q.push_back(32'd0);
        @(negedge clk);
        e = exp_q.pop_front(); tests++;
        if (bus.rd_data[0] !== e) begin fails++; $display("FAIL x0_bypass got=%h exp=%h", bus.rd_data[0], e); end
        e = exp_q.pop_front(); tests++;
        if (32'(bus.rd_busy[0]) !== e) begin fails++; $display("FAIL x0_busy0 got=%0d exp=%0d", bus.rd_busy[0], e); end
        cyc();
        exp_q.push_back(32'h0); exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        @(negedge clk);
        e = exp_q.pop_front(); tests++;
        if (bus.rd_data[0] !== e) begin fails++; $display("FAIL x0_stored got=%h exp=%h", bus.rd_data[0], e); end
        e = exp_q.pop_front(); tests++;
        if (32'(bus.rd_busy[0]) !== e) begin fails++; $display("FAIL x0_busy1 got=%0d exp=%0d", bus.rd_busy[0], e); end
        e = exp_q.pop_front(); tests++;
        if (32'(bus.pending_cnt) !== e) begin fails++; $display("FAIL x0_cnt got=%0d exp=%0d", bus.pending_cnt, e); end
        bus.wr_en[1] = 1'b1; bus.wr_addr[1] = 5'd20; bus.wr_data[1] = 32'h20;
        cyc();
    endtask
    task automatic test_back_to_back;
        for (int k = 0; k < 8; k++) begin
            cyc();
            bus.wr_en = 2'b11;
            bus.wr_addr[0] = 5'(16 + 2 * k); bus.wr_data[0] = $urandom;
            bus.wr_addr[1] = 5'(17 + 2 * k); bus.wr_data[1] = $urandom;
            model[16 + 2 * k] = bus.wr_data[0];
            model[17 + 2 * k] = bus.wr_data[1];
        end
        for (int k = 0; k < 8; k++) begin
            cyc();
            bus.rd_addr[0] = 5'(17 + 2 * k); bus.rd_addr[1] = 5'(16 + 2 * k);
            exp_q.push_back(model[17 + 2 * k]); exp_q.push_back(model[16 + 2 * k]);
            @(negedge clk);
            e = exp_q.pop_front(); tests++;
            if (bus.rd_data[0] !== e) begin fails++; $display("FAIL b2b_rd0 x%0d got=%h exp=%h", 17 + 2 * k, bus.rd_data[0], e); end
            e = exp_q.pop_front(); tests++;
            if (bus.rd_data[1] !== e) begin fails++; $display("FAIL b2b_rd1 x%0d got=%h exp=%h", 16 + 2 * k, bus.rd_data[1], e); end
        end
    endtask
    initial begin
        test_reset();
        test_bypass();
        test_dual_write();
        test_hazard();
        test_collision_flush();
        test_x0();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
